// File: rtl/tl_tx_scheduler_if.sv
// rtl/tl_tx_scheduler_if.sv - TLP beat/credit types and the scheduler's port interface
package tl_tx_scheduler_pkg;

    // Header counters are 8 bits, data counters 12 bits (16B units); rsvd pads to 76 bits.
    typedef struct packed {
        logic [15:0] rsvd;
        logic [7:0]  ph;
        logic [11:0] pd;
        logic [7:0]  nph;
        logic [11:0] npd;
        logic [7:0]  cplh;
        logic [11:0] cpld;
    } tl_credit_t;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   empty;
        logic         err;
        logic         sop;
        logic         eop;
    } tl_stream_t;

endpackage

interface tl_tx_scheduler_if #(parameter int DCRED_W = 9);
    import tl_tx_scheduler_pkg::*;

    logic               fc_upd_valid;
    tl_credit_t         fc_limit;
    logic               p_req, np_req, cpl_req;
    logic [DCRED_W-1:0] p_dcred, np_dcred, cpl_dcred;
    logic               p_gnt, np_gnt, cpl_gnt;
    tl_stream_t         p_in, np_in, cpl_in;
    logic               p_vld, np_vld, cpl_vld;
    logic               p_rdy, np_rdy, cpl_rdy;
    tl_stream_t         tx_out;
    logic               tx_valid;
    logic               tx_ready;
    tl_credit_t         cons_out;

    modport slave (
        input  fc_upd_valid, fc_limit,
        input  p_req, np_req, cpl_req, p_dcred, np_dcred, cpl_dcred,
        input  p_in, np_in, cpl_in, p_vld, np_vld, cpl_vld, tx_ready,
        output p_gnt, np_gnt, cpl_gnt, p_rdy, np_rdy, cpl_rdy,
        output tx_out, tx_valid, cons_out
    );

    modport master (
        output fc_upd_valid, fc_limit,
        output p_req, np_req, cpl_req, p_dcred, np_dcred, cpl_dcred,
        output p_in, np_in, cpl_in, p_vld, np_vld, cpl_vld, tx_ready,
        input  p_gnt, np_gnt, cpl_gnt, p_rdy, np_rdy, cpl_rdy,
        input  tx_out, tx_valid, cons_out
    );

endinterface

// File: rtl/tl_tx_scheduler.sv
// rtl/tl_tx_scheduler.sv - credit-gated round-robin TLP scheduler (P/NP/CPL); option TL_TX_SCHED_INF_CREDIT_EN
module tl_tx_scheduler
    import tl_tx_scheduler_pkg::*;
#(
    parameter int DCRED_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    tl_tx_scheduler_if.slave  bus
);

    localparam int HW = 8;
    localparam int DW = 12;

    typedef enum logic {S_IDLE, S_XFER} state_t;

    state_t                   state;
    logic [1:0]               sel;
    logic [1:0]               rr_ptr;
    logic [2:0][HW-1:0]       lim_h, cons_h, avail_h;
    logic [2:0][DW-1:0]       lim_d, cons_d, avail_d;
    logic [2:0]               inf_h, inf_d;

    logic [2:0]               req, vld, elig, gnt;
    logic [2:0][DCRED_W-1:0]  dcred;
    tl_stream_t [2:0]         beat;
    logic                     win_vld;
    logic [1:0]               win;
    logic [2:0]               cand;
    tl_stream_t               sel_beat;
    logic                     sel_vld;
    logic                     active;
    logic                     xfer;
    tl_credit_t               cons_s;
    logic                     unused_rsvd;

    // Class index 0 = P, 1 = NP, 2 = CPL throughout.
    assign req   = {bus.cpl_req, bus.np_req, bus.p_req};
    assign vld   = {bus.cpl_vld, bus.np_vld, bus.p_vld};
    assign dcred = {bus.cpl_dcred, bus.np_dcred, bus.p_dcred};
    assign beat  = {bus.cpl_in, bus.np_in, bus.p_in};
    assign unused_rsvd = ^bus.fc_limit.rsvd;

`ifdef TL_TX_SCHED_INF_CREDIT_EN
    logic upd_seen;

    // Zero fields in the first update after reset mean "unlimited" for that field.
    always_ff @(posedge clk) begin
        if (rst) begin
            inf_h    <= '0;
            inf_d    <= '0;
            upd_seen <= 1'b0;
        end else if (bus.fc_upd_valid && !upd_seen) begin
            upd_seen <= 1'b1;
            inf_h    <= {bus.fc_limit.cplh == '0, bus.fc_limit.nph == '0, bus.fc_limit.ph == '0};
            inf_d    <= {bus.fc_limit.cpld == '0, bus.fc_limit.npd == '0, bus.fc_limit.pd == '0};
        end
    end
`else
    assign inf_h = '0;
    assign inf_d = '0;
`endif

    always_comb begin
        avail_h = '0;
        avail_d = '0;
        elig    = '0;
        for (int i = 0; i < 3; i++) begin
            avail_h[i] = lim_h[i] - cons_h[i];
            avail_d[i] = lim_d[i] - cons_d[i];
            elig[i]    = req[i] & (inf_h[i] | (avail_h[i] != '0))
                                & (inf_d[i] | (avail_d[i] >= DW'(dcred[i])));
        end
    end

    always_comb begin
        win_vld = 1'b0;
        win     = 2'd0;
        cand    = 3'd0;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, rr_ptr} + 3'(k);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (!win_vld && elig[cand[1:0]]) begin
                win_vld = 1'b1;
                win     = cand[1:0];
            end
        end
    end

    always_comb begin
        sel_beat = '0;
        sel_vld  = 1'b0;
        case (sel)
            2'd0:    begin sel_beat = beat[0]; sel_vld = vld[0]; end
            2'd1:    begin sel_beat = beat[1]; sel_vld = vld[1]; end
            2'd2:    begin sel_beat = beat[2]; sel_vld = vld[2]; end
            default: begin sel_beat = '0;      sel_vld = 1'b0;   end
        endcase
    end

    // Outputs are forced quiet while rst is asserted so the reset cycle itself is clean.
    assign active       = !rst && (state == S_XFER);
    assign xfer         = (state == S_XFER) && sel_vld && bus.tx_ready;
    assign gnt          = (!rst && state == S_IDLE && win_vld) ? (3'b001 << win) : 3'b000;
    assign bus.p_gnt    = gnt[0];
    assign bus.np_gnt   = gnt[1];
    assign bus.cpl_gnt  = gnt[2];
    assign bus.tx_out   = active ? sel_beat : '0;
    assign bus.tx_valid = active && sel_vld;
    assign bus.p_rdy    = active && (sel == 2'd0) && bus.tx_ready;
    assign bus.np_rdy   = active && (sel == 2'd1) && bus.tx_ready;
    assign bus.cpl_rdy  = active && (sel == 2'd2) && bus.tx_ready;

    always_comb begin
        cons_s      = '0;
        cons_s.ph   = cons_h[0];
        cons_s.pd   = cons_d[0];
        cons_s.nph  = cons_h[1];
        cons_s.npd  = cons_d[1];
        cons_s.cplh = cons_h[2];
        cons_s.cpld = cons_d[2];
    end
    assign bus.cons_out = cons_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            sel    <= 2'd0;
            rr_ptr <= 2'd0;
            lim_h  <= '0;
            lim_d  <= '0;
            cons_h <= '0;
            cons_d <= '0;
        end else begin
            // Arbitration this cycle already used the old limits; the update lands for next cycle.
            if (bus.fc_upd_valid) begin
                lim_h <= {bus.fc_limit.cplh, bus.fc_limit.nph, bus.fc_limit.ph};
                lim_d <= {bus.fc_limit.cpld, bus.fc_limit.npd, bus.fc_limit.pd};
            end
            case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        if (!inf_h[win]) cons_h[win] <= cons_h[win] + HW'(1);
                        if (!inf_d[win]) cons_d[win] <= cons_d[win] + DW'(dcred[win]);
                        sel    <= win;
                        rr_ptr <= (win == 2'd2) ? 2'd0 : win + 2'd1;
                        state  <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (xfer && sel_beat.eop) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tl_tx_scheduler.sv
// tb/tb_tl_tx_scheduler.sv - randomized scoreboard bench for tl_tx_scheduler
module tb_tl_tx_scheduler;
    import tl_tx_scheduler_pkg::*;

`ifdef TL_TX_SCHED_INF_CREDIT_EN
    localparam bit INF_EN = 1'b1;
`else
    localparam bit INF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tl_tx_scheduler_if #(.DCRED_W(9)) bus();
    tl_tx_scheduler #(.DCRED_W(9)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int checks = 0;
    int failures = 0;

    // Reference: credit ledger per class, "last winner" for round-robin, one TLP in flight.
    int  lim_h[3], lim_d[3], cons_h[3], cons_d[3];
    bit  inf_h[3], inf_d[3];
    bit  seen;
    bit  busy;
    int  cur, last;
    int  ngr[3];

    bit         pend[3];
    int         pend_len[3], pend_dcred[3];
    tl_stream_t pend_b[3][4];
    tl_stream_t act_b[4];
    int         act_len, act_idx;
    bit         hold;
    tl_stream_t exp_q[$];

    bit         req_a[3], vld_a[3];
    int         dcr_a[3];
    tl_stream_t in_a[3];
    bit         tx_rdy;
    int         stall_cnt;

    bit req_en, upd_en, do_rst, chk_en, force_upd;
    int rdy_pct, max_dcred;
    int force_h[3], force_d[3];

    task automatic chk(string name, logic [191:0] got, logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic int avail(int lim, int cons, int w);
        return (lim - cons + (1 << w)) % (1 << w);
    endfunction

    function automatic bit elig(int c);
        return req_a[c] && (inf_h[c] || avail(lim_h[c], cons_h[c], 8) >= 1)
                        && (inf_d[c] || avail(lim_d[c], cons_d[c], 12) >= dcr_a[c]);
    endfunction

    function automatic tl_stream_t rand_beat();
        tl_stream_t b;
        b.data  = {$urandom, $urandom, $urandom, $urandom};
        b.empty = 4'($urandom);
        b.err   = 1'($urandom);
        b.sop   = 1'($urandom);
        b.eop   = 1'($urandom);
        return b;
    endfunction

    function automatic tl_credit_t pack_cons();
        tl_credit_t t;
        t      = '0;
        t.ph   = 8'(cons_h[0]);  t.pd   = 12'(cons_d[0]);
        t.nph  = 8'(cons_h[1]);  t.npd  = 12'(cons_d[1]);
        t.cplh = 8'(cons_h[2]);  t.cpld = 12'(cons_d[2]);
        return t;
    endfunction

    function automatic bit any_pend();
        return pend[0] || pend[1] || pend[2];
    endfunction

    task automatic new_tlp(int c);
        tl_stream_t b;
        pend_len[c]   = $urandom_range(1, 4);
        pend_dcred[c] = (c == 1 && $urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, max_dcred);
        for (int i = 0; i < pend_len[c]; i++) begin
            b.data  = {$urandom, $urandom, $urandom, $urandom};
            b.empty = 4'($urandom);
            b.err   = 1'b0;
            b.sop   = (i == 0);
            b.eop   = (i == pend_len[c] - 1);
            pend_b[c][i] = b;
        end
        pend[c] = 1'b1;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            lim_h[c] = 0; lim_d[c] = 0; cons_h[c] = 0; cons_d[c] = 0;
            inf_h[c] = 0; inf_d[c] = 0;
        end
        seen = 0; busy = 0; cur = 0; last = 2;
        act_len = 0; act_idx = 0; hold = 0;
        exp_q.delete();
    endtask

    task automatic cycle();
        int w, c;
        bit upd;
        int nh[3], nd[3];
        tl_credit_t fl;
        logic [2:0] eg, er;
        tl_stream_t exp_tx;

        @(negedge clk);
        for (int k = 0; k < 3; k++)
            if (req_en && !pend[k] && $urandom_range(0, 3) == 0) new_tlp(k);
        for (int k = 0; k < 3; k++) begin
            req_a[k] = pend[k];
            dcr_a[k] = pend[k] ? pend_dcred[k] : $urandom_range(0, 511);
            if (busy && cur == k) begin
                vld_a[k] = (act_idx < act_len) && (hold || $urandom_range(0, 3) != 0);
                in_a[k]  = vld_a[k] ? act_b[act_idx] : rand_beat();
            end else begin
                vld_a[k] = 1'($urandom);
                in_a[k]  = rand_beat();
            end
        end
        if (do_rst) tx_rdy = 1'b0;
        else if (stall_cnt > 0) begin tx_rdy = 1'b0; stall_cnt--; end
        else if ($urandom_range(0, 49) == 0) begin tx_rdy = 1'b0; stall_cnt = 4; end
        else tx_rdy = ($urandom_range(0, 99) < rdy_pct);

        upd = force_upd || (upd_en && $urandom_range(0, 7) == 0);
        for (int k = 0; k < 3; k++) begin
            if (force_upd) begin
                nh[k] = force_h[k]; nd[k] = force_d[k];
            end else begin
                nh[k] = ($urandom_range(0, 15) == 0) ? 0 : (cons_h[k] + $urandom_range(0, 6)) % 256;
                nd[k] = ($urandom_range(0, 15) == 0) ? 0 : (cons_d[k] + $urandom_range(0, 600)) % 4096;
            end
        end
        fl.rsvd = 16'($urandom);
        fl.ph   = 8'(nh[0]);  fl.pd   = 12'(nd[0]);
        fl.nph  = 8'(nh[1]);  fl.npd  = 12'(nd[1]);
        fl.cplh = 8'(nh[2]);  fl.cpld = 12'(nd[2]);

        rst              = do_rst;
        bus.p_req        = req_a[0];  bus.np_req   = req_a[1];  bus.cpl_req   = req_a[2];
        bus.p_dcred      = 9'(dcr_a[0]); bus.np_dcred = 9'(dcr_a[1]); bus.cpl_dcred = 9'(dcr_a[2]);
        bus.p_vld        = vld_a[0];  bus.np_vld   = vld_a[1];  bus.cpl_vld   = vld_a[2];
        bus.p_in         = in_a[0];   bus.np_in    = in_a[1];   bus.cpl_in    = in_a[2];
        bus.tx_ready     = tx_rdy;
        bus.fc_upd_valid = upd;
        bus.fc_limit     = fl;
        #1;

        w = -1;
        if (!do_rst && !busy)
            for (int k = 1; k <= 3; k++) begin
                c = (last + k) % 3;
                if (w < 0 && elig(c)) w = c;
            end
        eg = (w >= 0) ? 3'(1 << w) : 3'b000;
        er = (!do_rst && busy && tx_rdy) ? 3'(1 << cur) : 3'b000;
        exp_tx = (!do_rst && busy) ? in_a[cur] : '0;
        if (chk_en) begin
            chk("gnt", {bus.cpl_gnt, bus.np_gnt, bus.p_gnt}, eg);
            chk("src_rdy", {bus.cpl_rdy, bus.np_rdy, bus.p_rdy}, er);
            chk("tx_valid", bus.tx_valid, !do_rst && busy && vld_a[cur]);
            chk("tx_out", bus.tx_out, exp_tx);
            chk("cons_out", bus.cons_out, pack_cons());
        end

        if (do_rst) begin
            model_reset();
        end else begin
            if (w >= 0) begin
                if (!inf_h[w]) cons_h[w] = (cons_h[w] + 1) % 256;
                if (!inf_d[w]) cons_d[w] = (cons_d[w] + pend_dcred[w]) % 4096;
                busy = 1; cur = w; last = w; hold = 0;
                act_len = pend_len[w]; act_idx = 0;
                for (int i = 0; i < act_len; i++) begin
                    act_b[i] = pend_b[w][i];
                    exp_q.push_back(pend_b[w][i]);
                end
                pend[w] = 0;
                ngr[w]++;
            end else if (busy && vld_a[cur] && tx_rdy) begin
                if (act_b[act_idx].eop) busy = 0;
                act_idx++;
                hold = 0;
            end else if (busy && vld_a[cur]) begin
                hold = 1;
            end
            if (upd) begin
                if (INF_EN && !seen)
                    for (int k = 0; k < 3; k++) begin
                        inf_h[k] = (nh[k] == 0);
                        inf_d[k] = (nd[k] == 0);
                    end
                seen = 1;
                for (int k = 0; k < 3; k++) begin
                    lim_h[k] = nh[k];
                    lim_d[k] = nd[k];
                end
            end
        end
    endtask

    // Scoreboard monitor: every accepted DLL beat must be the next expected beat.
    initial begin
        tl_stream_t e;
        forever begin
            @(negedge clk);
            #2;
            if (chk_en && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_extra: got=%0h expected=none", bus.tx_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("scoreboard_beat", bus.tx_out, e);
                end
            end
        end
    end

    initial begin
        int n;
        do_rst = 1; req_en = 0; upd_en = 0; chk_en = 0; force_upd = 0;
        rdy_pct = 70; max_dcred = 4; stall_cnt = 0;
        for (int k = 0; k < 3; k++) begin pend[k] = 0; ngr[k] = 0; end
        model_reset();
        repeat (3) cycle();
        do_rst = 0;
        chk_en = 1;

        // Requests with no credits ever advertised: nothing may be granted.
        req_en = 1;
        repeat (20) cycle();

        force_upd = 1;
        force_h[0] = 2; force_h[1] = 0; force_h[2] = 0;
        force_d[0] = 8; force_d[1] = 0; force_d[2] = 0;
        cycle();
        force_upd = 0;
        repeat (40) cycle();

        max_dcred = 256;
        upd_en = 1;
        repeat (3000) cycle();

        n = 0;
        while (!(busy && act_idx > 0) && n < 500) begin cycle(); n++; end
        if (n >= 500) begin
            checks++;
            failures++;
            $display("FAIL wait_mid_tlp: got=timeout expected=busy");
        end
        do_rst = 1;
        cycle();
        do_rst = 0;
        repeat (2500) cycle();

        req_en = 0;
        rdy_pct = 100;
        n = 0;
        while ((busy || exp_q.size() > 0 || any_pend()) && n < 3000) begin cycle(); n++; end
        repeat (2) cycle();
        chk("drain_exp_q_empty", exp_q.size(), 0);
        chk("drain_model_idle", busy, 0);
        chk("grants_p_seen", ngr[0] > 0, 1);
        chk("grants_np_seen", ngr[1] > 0, 1);
        chk("grants_cpl_seen", ngr[2] > 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
